// File: rtl/int_sequencer_if.sv
// Pipeline-side bundle for the interrupt sequencer: request/hazard inputs in,
// fetch/decode control, stack push and PC-load outputs back to the pipeline.
interface int_sequencer_if;
    logic        int_req;
    logic [2:0]  i_index;
    logic        i_hazard_stall;
    logic        i_branch;
    logic [31:0] i_pc;
    logic [3:0]  i_flags;
    logic        i_mem_ready;
    logic        o_fetch_en;
    logic        o_bubble;
    logic        o_push;
    logic        o_push_32;
    logic [31:0] o_push_data;
    logic        o_pc_load;
    logic [31:0] o_pc_target;
    logic        o_int_ack;
    logic        o_busy;

    modport master (
        output int_req, i_index, i_hazard_stall, i_branch, i_pc, i_flags, i_mem_ready,
        input  o_fetch_en, o_bubble, o_push, o_push_32, o_push_data,
               o_pc_load, o_pc_target, o_int_ack, o_busy
    );

    modport slave (
        input  int_req, i_index, i_hazard_stall, i_branch, i_pc, i_flags, i_mem_ready,
        output o_fetch_en, o_bubble, o_push, o_push_32, o_push_data,
               o_pc_load, o_pc_target, o_int_ack, o_busy
    );
endinterface

// File: rtl/int_sequencer.sv
// Interrupt sequencer: drains the pipeline, pushes return PC and CCR flags,
// then redirects fetch to the IVT entry. Outputs are decoded from state only.
module int_sequencer #(
    parameter int unsigned DRAIN_CYCLES = 3,
    parameter logic [31:0] IVT_BASE     = 32'd12
) (
    input  logic           clk,
    input  logic           rst,
    int_sequencer_if.slave bus
);
    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] DRAIN    = 3'd1;
    localparam logic [2:0] PUSH_PC  = 3'd2;
    localparam logic [2:0] PUSH_FLG = 3'd3;
    localparam logic [2:0] VECTOR   = 3'd4;

    localparam logic [2:0] CNT_INIT = 3'(DRAIN_CYCLES - 1);

    logic [2:0]  state;
    logic        pending;
    logic [31:0] savePc;
    logic [2:0]  saveIdx;
    logic [3:0]  saveFlags;
    logic [2:0]  cnt;
    logic        accept;

    // A live request bypasses the pending register so accept can happen the same cycle.
    assign accept = (state == IDLE) && (pending || bus.int_req)
                    && !bus.i_hazard_stall && !bus.i_branch;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            pending   <= 1'b0;
            savePc    <= '0;
            saveIdx   <= '0;
            saveFlags <= '0;
            cnt       <= '0;
        end else begin
            pending <= accept ? 1'b0 : (pending || bus.int_req);
            case (state)
                IDLE: begin
                    if (accept) begin
                        savePc  <= bus.i_pc;
                        saveIdx <= bus.i_index;
                        cnt     <= CNT_INIT;
                        state   <= DRAIN;
                    end
                end
                DRAIN: begin
                    // Flags are taken on the last drain edge, once older instructions have retired.
                    if (cnt == '0) begin
                        saveFlags <= bus.i_flags;
                        state     <= PUSH_PC;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                PUSH_PC:  if (bus.i_mem_ready) state <= PUSH_FLG;
                PUSH_FLG: if (bus.i_mem_ready) state <= VECTOR;
                VECTOR:   state <= IDLE;
                default:  state <= IDLE;
            endcase
        end
    end

    always_comb begin
        bus.o_fetch_en  = 1'b1;
        bus.o_bubble    = 1'b0;
        bus.o_push      = 1'b0;
        bus.o_push_32   = 1'b0;
        bus.o_push_data = '0;
        bus.o_pc_load   = 1'b0;
        bus.o_pc_target = '0;
        bus.o_int_ack   = 1'b0;
        bus.o_busy      = (state != IDLE);
        case (state)
            DRAIN: begin
                bus.o_fetch_en = 1'b0;
                bus.o_bubble   = 1'b1;
            end
            PUSH_PC: begin
                bus.o_fetch_en  = 1'b0;
                bus.o_bubble    = 1'b1;
                bus.o_push      = 1'b1;
                bus.o_push_32   = 1'b1;
                bus.o_push_data = savePc;
            end
            PUSH_FLG: begin
                bus.o_fetch_en  = 1'b0;
                bus.o_bubble    = 1'b1;
                bus.o_push      = 1'b1;
                bus.o_push_data = {28'b0, saveFlags};
            end
            VECTOR: begin
                bus.o_bubble    = 1'b1;
                bus.o_pc_load   = 1'b1;
                bus.o_pc_target = IVT_BASE + {28'b0, saveIdx, 1'b0};
                bus.o_int_ack   = 1'b1;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_int_sequencer.sv
// Bench for int_sequencer: directed vector table, hand sequences for corner
// cases, and random traffic against a phase-counting reference model.
module tb_int_sequencer;
    typedef struct packed {
        logic        fetch;
        logic        bubble;
        logic        push;
        logic        push32;
        logic [31:0] pdata;
        logic        pcload;
        logic [31:0] target;
        logic        ack;
        logic        busy;
    } outs_t;

    typedef struct {
        logic        req;
        logic [2:0]  idx;
        logic [31:0] pc;
        logic [3:0]  flags;
        logic        ready;
        outs_t       exp0;
        logic [31:0] expT1;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req, stall, branch, ready;
    logic [2:0]  idx;
    logic [31:0] pc;
    logic [3:0]  flags;

    int total = 0;
    int bad = 0;
    int acks0 = 0;

    int_sequencer_if bus0();
    int_sequencer_if bus1();

    assign bus0.int_req = req;        assign bus1.int_req = req;
    assign bus0.i_index = idx;        assign bus1.i_index = idx;
    assign bus0.i_hazard_stall = stall; assign bus1.i_hazard_stall = stall;
    assign bus0.i_branch = branch;    assign bus1.i_branch = branch;
    assign bus0.i_pc = pc;            assign bus1.i_pc = pc;
    assign bus0.i_flags = flags;      assign bus1.i_flags = flags;
    assign bus0.i_mem_ready = ready;  assign bus1.i_mem_ready = ready;

    outs_t obs0, obs1;
    assign obs0 = {bus0.o_fetch_en, bus0.o_bubble, bus0.o_push, bus0.o_push_32, bus0.o_push_data,
                   bus0.o_pc_load, bus0.o_pc_target, bus0.o_int_ack, bus0.o_busy};
    assign obs1 = {bus1.o_fetch_en, bus1.o_bubble, bus1.o_push, bus1.o_push_32, bus1.o_push_data,
                   bus1.o_pc_load, bus1.o_pc_target, bus1.o_int_ack, bus1.o_busy};

    int_sequencer #(.DRAIN_CYCLES(3), .IVT_BASE(32'd12)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    int_sequencer #(.DRAIN_CYCLES(1), .IVT_BASE(32'hFFFF_FFFC)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    always #5 clk = ~clk;

    // Reference model: phase 0 idle, 1..D drain, D+1 push PC, D+2 push flags, D+3 vector.
    int unsigned mD[2]   = '{3, 1};
    logic [31:0] mBase[2] = '{32'd12, 32'hFFFF_FFFC};
    int unsigned mPhase[2];
    bit          mPending[2];
    logic [31:0] mPc[2];
    logic [2:0]  mIdx[2];
    logic [3:0]  mFlags[2];

    function automatic outs_t mk(logic f, logic b, logic p, logic p32, logic [31:0] pd,
                                 logic pl, logic [31:0] t, logic a, logic bz);
        return {f, b, p, p32, pd, pl, t, a, bz};
    endfunction

    task automatic modelReset();
        for (int k = 0; k < 2; k++) begin
            mPhase[k] = 0; mPending[k] = 0; mPc[k] = '0; mIdx[k] = '0; mFlags[k] = '0;
        end
    endtask

    task automatic modelAdvance(input int k);
        bit acc;
        int unsigned d;
        d = mD[k];
        acc = (mPhase[k] == 0) && (mPending[k] || req) && !stall && !branch;
        mPending[k] = acc ? 1'b0 : (mPending[k] || req);
        if (mPhase[k] == 0) begin
            if (acc) begin
                mPc[k] = pc; mIdx[k] = idx; mPhase[k] = 1;
            end
        end else if (mPhase[k] <= d) begin
            if (mPhase[k] == d) mFlags[k] = flags;
            mPhase[k]++;
        end else if (mPhase[k] <= d + 2) begin
            if (ready) mPhase[k]++;
        end else begin
            mPhase[k] = 0;
        end
    endtask

    function automatic outs_t modelOut(input int k);
        int unsigned ph, d;
        logic [31:0] tgt;
        ph = mPhase[k];
        d = mD[k];
        tgt = mBase[k] + 32'(mIdx[k]) * 32'd2;
        if (ph == 0)          return mk(1, 0, 0, 0, 0, 0, 0, 0, 0);
        else if (ph <= d)     return mk(0, 1, 0, 0, 0, 0, 0, 0, 1);
        else if (ph == d + 1) return mk(0, 1, 1, 1, mPc[k], 0, 0, 0, 1);
        else if (ph == d + 2) return mk(0, 1, 1, 0, {28'b0, mFlags[k]}, 0, 0, 0, 1);
        else                  return mk(1, 1, 0, 0, 0, 1, tgt, 1, 1);
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, got, exp);
        end
    endtask

    task automatic cmpModel();
        outs_t e;
        e = modelOut(0);
        total++;
        if (obs0 !== e) begin
            bad++;
            $display("FAIL model_dut0 t=%0t: got %h want %h", $time, obs0, e);
        end
        e = modelOut(1);
        total++;
        if (obs1 !== e) begin
            bad++;
            $display("FAIL model_dut1 t=%0t: got %h want %h", $time, obs1, e);
        end
    endtask

    task automatic step();
        @(posedge clk);
        modelAdvance(0);
        modelAdvance(1);
        #1;
        acks0 += int'(obs0.ack);
        cmpModel();
    endtask

    task automatic doReset();
        rst = 1'b1;
        #1;
        modelReset();
        chk("reset_fetch_en", 32'(obs0.fetch), 32'd1);
        chk("reset_busy", 32'(obs0.busy), 32'd0);
        chk("reset_push", 32'(obs0.push), 32'd0);
        cmpModel();
        #2;
        rst = 1'b0;
    endtask

    task automatic idleSteps(input int n);
        req = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    vec_t tbl[7];
    int n;

    initial begin
        rst = 1'b1; req = 0; stall = 0; branch = 0; ready = 1; idx = 0; pc = 0; flags = 0;
        #1;
        modelReset();
        chk("por_fetch_en", 32'(obs0.fetch), 32'd1);
        chk("por_busy", 32'(obs0.busy), 32'd0);
        #1;
        rst = 1'b0;

        tbl[0] = '{1'b1, 3'd3, 32'h40, 4'hA, 1'b1, mk(0,1,0,0,0,0,0,0,1), 32'h0};
        tbl[1] = '{1'b0, 3'd3, 32'h40, 4'hA, 1'b1, mk(0,1,0,0,0,0,0,0,1), 32'h0};
        tbl[2] = '{1'b0, 3'd3, 32'h40, 4'hA, 1'b1, mk(0,1,0,0,0,0,0,0,1), 32'h0};
        tbl[3] = '{1'b0, 3'd3, 32'h40, 4'hA, 1'b1, mk(0,1,1,1,32'h40,0,0,0,1), 32'h2};
        tbl[4] = '{1'b0, 3'd3, 32'h40, 4'hA, 1'b1, mk(0,1,1,0,32'hA,0,0,0,1), 32'h0};
        tbl[5] = '{1'b0, 3'd3, 32'h40, 4'hA, 1'b1, mk(1,1,0,0,0,1,32'd18,1,1), 32'h0};
        tbl[6] = '{1'b0, 3'd3, 32'h40, 4'hA, 1'b1, mk(1,0,0,0,0,0,0,0,0), 32'h0};

        for (int i = 0; i < 7; i++) begin
            req = tbl[i].req; idx = tbl[i].idx; pc = tbl[i].pc;
            flags = tbl[i].flags; ready = tbl[i].ready;
            step();
            total++;
            if (obs0 !== tbl[i].exp0) begin
                bad++;
                $display("FAIL table_row%0d: got %h want %h", i, obs0, tbl[i].exp0);
            end
            chk($sformatf("table_wrap_target_row%0d", i), obs1.target, tbl[i].expT1);
        end
        idleSteps(2);

        // Reset in the middle of DRAIN, then a fresh full sequence.
        req = 1; pc = 32'h1234_5678; idx = 5; flags = 4'h3;
        step();
        req = 0;
        step();
        doReset();
        step();
        req = 1;
        step();
        req = 0;
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (obs0.ack) begin n = i; break; end
        end
        chk("post_reset_ack_latency", 32'(n), 32'd5);
        idleSteps(3);

        // Accept held off by hazard stall, then by branch.
        for (int kind = 0; kind < 2; kind++) begin
            if (kind == 0) stall = 1; else branch = 1;
            req = 1;
            step();
            req = 0;
            for (int i = 0; i < 3; i++) step();
            chk(kind == 0 ? "stall_blocks" : "branch_blocks", 32'(obs0.busy), 32'd0);
            stall = 0; branch = 0;
            step();
            chk(kind == 0 ? "stall_release_accept" : "branch_release_accept", 32'(obs0.busy), 32'd1);
            idleSteps(10);
        end

        // Memory backpressure: 2 waits in PUSH_PC, 1 in PUSH_FLG.
        pc = 32'hCAFE_0010; idx = 1; flags = 4'h5;
        req = 1; ready = 1;
        step();
        req = 0;
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            ready = !(i == 4 || i == 5 || i == 7);
            step();
            if (i == 4 || i == 5) chk($sformatf("stall_push_data_%0d", i), obs0.pdata, 32'hCAFE_0010);
            if (i == 7) chk("stall_flag_data", obs0.pdata, 32'h5);
            if (obs0.ack) begin n = i; break; end
        end
        ready = 1;
        chk("backpressure_ack_latency", 32'(n), 32'd8);
        idleSteps(3);

        // Back-to-back: extra requests during the first sequence merge into one.
        acks0 = 0;
        pc = 32'h200; idx = 2; flags = 4'h9;
        req = 1; step();
        step();
        req = 0; step(); step(); step();
        req = 1; step();
        req = 0; step();
        chk("b2b_gap_busy", 32'(obs0.busy), 32'd0);
        chk("b2b_gap_bubble", 32'(obs0.bubble), 32'd0);
        chk("b2b_gap_fetch", 32'(obs0.fetch), 32'd1);
        step();
        chk("b2b_second_start", 32'(obs0.busy), 32'd1);
        idleSteps(20);
        chk("b2b_ack_count", 32'(acks0), 32'd2);

        // Random traffic against the model.
        for (int i = 0; i < 2000; i++) begin
            req    = ($urandom % 8) == 0;
            stall  = ($urandom % 4) == 0;
            branch = ($urandom % 5) == 0;
            ready  = ($urandom % 4) != 0;
            idx    = 3'($urandom);
            pc     = $urandom;
            flags  = 4'($urandom);
            if (($urandom % 250) == 0) doReset();
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
